// File: rtl/mil_rx_pkg.sv
// Shared types for the MIL-STD-1553 receive packet buffer.
// WordType encodes the 2-bit word tag stored next to every 16-bit word;
// BufEntry is the 18-bit buffer entry; header field positions live here too.
package mil_rx_pkg;

  typedef enum logic [1:0] {
    CMD  = 2'd0,
    DATA = 2'd1,
    ERR  = 2'd2,
    HDR  = 2'd3
  } WordType;

  typedef struct packed {
    WordType     wtype;
    logic [15:0] data;
  } BufEntry;

  localparam int HDR_ERR_BIT = 15;
  localparam int HDR_CNT_W   = 6;

  // Header word: error flag in bit 15, word count in the low bits.
  function automatic logic [15:0] mkHeader(input logic err,
                                           input logic [HDR_CNT_W-1:0] cnt);
    logic [15:0] h;
    h                  = '0;
    h[HDR_ERR_BIT]     = err;
    h[HDR_CNT_W-1:0]   = cnt;
    return h;
  endfunction

endpackage

// File: rtl/mil_rx_word_ram.sv
// Simple dual-port word RAM, DEPTH x 18 bits.
// Ports: clk; we/waddr/wdata write port; re/raddr read port with
// rdata registered one cycle after re.
module mil_rx_word_ram
  import mil_rx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  BufEntry       wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output BufEntry       rdata
);

  BufEntry mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mil_rx_packet_buffer.sv
// Receive packet buffer behind the MIL-STD-1553 transceiver.
// Words between packet_start/packet_end are written behind a reserved
// header slot; on a clean end the header is filled in and the packet is
// committed. Overflow, overlength and (by default) error words drop the
// whole packet. Committed words leave through pop_valid/pop_ack.
// Ports: clk, rst (async active-low); in_request/in_data/in_type,
// packet_start, packet_end from the receiver; pop_valid/pop_data/pop_type/
// pop_ack to the reader; packets_pending, drop_strobe status.
// Build option: define MIL_RX_ERR_KEEP_EN to keep error words in the
// packet and flag them in header bit 15 instead of dropping the packet.
module mil_rx_packet_buffer
  import mil_rx_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int MAX_WORDS = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_request,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_type,
  input  logic        packet_start,
  input  logic        packet_end,
  output logic        pop_valid,
  output logic [15:0] pop_data,
  output logic [1:0]  pop_type,
  input  logic        pop_ack,
  output logic [5:0]  packets_pending,
  output logic        drop_strobe
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]        DEPTH_P = PW'(DEPTH);
  localparam logic [HDR_CNT_W-1:0] MAX_CNT = HDR_CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, RECEIVE, COMMIT, DROP} State;

  State                 state;
  logic [PW-1:0]        wrPtr, commitPtr, rdPtr;
  logic [HDR_CNT_W-1:0] wcount;
  logic                 errSeen;
  logic                 rdPending;

  // ---------------- write-side decode ----------------
  logic          isErr, errDrops, full, wordDrop, wordWr, roomForStart;
  logic [PW-1:0] used, startBase, baseUsed;

  assign isErr = (in_type == ERR);
`ifdef MIL_RX_ERR_KEEP_EN
  assign errDrops = 1'b0;
`else
  assign errDrops = isErr;
`endif

  assign used     = wrPtr - rdPtr;
  assign full     = (used == DEPTH_P);
  assign wordDrop = in_request && (errDrops || full || wcount == MAX_CNT);
  assign wordWr   = in_request && !wordDrop;

  // A new packet starts right after the last committed word; in COMMIT
  // that boundary is wrPtr since commitPtr has not moved yet.
  assign startBase    = (state == COMMIT) ? wrPtr : commitPtr;
  assign baseUsed     = startBase - rdPtr;
  assign roomForStart = (DEPTH_P - baseUsed) >= PW'(2);

  // ---------------- RAM ----------------
  logic          ramWe, rdIssue;
  logic [AW-1:0] ramWaddr;
  BufEntry       ramWdata, ramRdata;

  always_comb begin
    ramWe    = 1'b0;
    ramWaddr = wrPtr[AW-1:0];
    ramWdata = '{wtype: WordType'(in_type), data: in_data};
    if (state == RECEIVE && !packet_start && wordWr) begin
      ramWe = 1'b1;
    end else if (state == COMMIT) begin
      ramWe    = 1'b1;
      ramWaddr = commitPtr[AW-1:0];
      ramWdata = '{wtype: HDR, data: mkHeader(errSeen, wcount)};
    end
  end

  mil_rx_word_ram #(.DEPTH(DEPTH), .AW(AW)) uRam (
    .clk   (clk),
    .we    (ramWe),
    .waddr (ramWaddr),
    .wdata (ramWdata),
    .re    (rdIssue),
    .raddr (rdPtr[AW-1:0]),
    .rdata (ramRdata)
  );

  // ---------------- packet FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wrPtr       <= '0;
      commitPtr   <= '0;
      wcount      <= '0;
      errSeen     <= 1'b0;
      drop_strobe <= 1'b0;
    end else begin
      drop_strobe <= 1'b0;
      case (state)
        IDLE, DROP: begin
          if (packet_start) begin
            if (roomForStart) begin
              state   <= RECEIVE;
              wrPtr   <= commitPtr + 1'b1;
              wcount  <= '0;
              errSeen <= 1'b0;
            end else begin
              state       <= DROP;
              drop_strobe <= 1'b1;
              wrPtr       <= commitPtr;
            end
          end else if (state == DROP && packet_end) begin
            state <= IDLE;
          end
        end

        RECEIVE: begin
          if (packet_start) begin
            // restart: header slot stays reserved, partial words discarded
            wrPtr   <= commitPtr + 1'b1;
            wcount  <= '0;
            errSeen <= 1'b0;
          end else if (wordDrop) begin
            drop_strobe <= 1'b1;
            wrPtr       <= commitPtr;
            state       <= packet_end ? IDLE : DROP;
          end else begin
            if (wordWr) begin
              wrPtr  <= wrPtr + 1'b1;
              wcount <= wcount + 1'b1;
              if (isErr) errSeen <= 1'b1;
            end
            // a word arriving with the end strobe belongs to the packet
            if (packet_end) begin
              if (wordWr || wcount != '0) begin
                state <= COMMIT;
              end else begin
                state <= IDLE;
                wrPtr <= commitPtr;
              end
            end
          end
        end

        COMMIT: begin
          commitPtr <= wrPtr;
          if (packet_start) begin
            if (roomForStart) begin
              state   <= RECEIVE;
              wrPtr   <= wrPtr + 1'b1;
              wcount  <= '0;
              errSeen <= 1'b0;
            end else begin
              state       <= DROP;
              drop_strobe <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- read side ----------------
  // issue -> RAM output (rdPending) -> output register; 3 cycles per word
  logic ackFire, hdrAck, commitNow;

  assign ackFire = pop_ack && pop_valid;
  assign rdIssue = (rdPtr != commitPtr) && !pop_valid && !rdPending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr     <= '0;
      rdPending <= 1'b0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
      pop_type  <= '0;
    end else begin
      rdPending <= rdIssue;
      if (rdPending) begin
        pop_valid <= 1'b1;
        pop_data  <= ramRdata.data;
        pop_type  <= ramRdata.wtype;
      end else if (ackFire) begin
        pop_valid <= 1'b0;
        rdPtr     <= rdPtr + 1'b1;
      end
    end
  end

  // ---------------- pending packet count ----------------
  assign commitNow = (state == COMMIT);
  assign hdrAck    = ackFire && (pop_type == HDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      packets_pending <= '0;
    end else begin
      case ({commitNow, hdrAck})
        2'b10: if (packets_pending != 6'd63) packets_pending <= packets_pending + 1'b1;
        2'b01: if (packets_pending != 6'd0)  packets_pending <= packets_pending - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mil_rx_packet_buffer.sv
// Scoreboard bench for mil_rx_packet_buffer: expected words are queued as
// packets are driven and compared in order as the DUT pops them.
module tb_mil_rx_packet_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_request = 1'b0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_type = '0;
  logic        packet_start = 1'b0;
  logic        packet_end = 1'b0;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic [1:0]  pop_type;
  logic        pop_ack = 1'b0;
  logic [5:0]  packets_pending;
  logic        drop_strobe;

  int nCmp = 0;
  int nErr = 0;
  int dropCnt = 0;
  logic [17:0] sbq[$];

  mil_rx_packet_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .in_request      (in_request),
    .in_data         (in_data),
    .in_type         (in_type),
    .packet_start    (packet_start),
    .packet_end      (packet_end),
    .pop_valid       (pop_valid),
    .pop_data        (pop_data),
    .pop_type        (pop_type),
    .pop_ack         (pop_ack),
    .packets_pending (packets_pending),
    .drop_strobe     (drop_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (drop_strobe) dropCnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulseStart();
    packet_start = 1'b1; @(negedge clk); packet_start = 1'b0;
  endtask

  task automatic sendWord(input logic [1:0] t, input logic [15:0] d);
    in_request = 1'b1; in_type = t; in_data = d;
    @(negedge clk);
    in_request = 1'b0;
  endtask

  // end strobe plus one cycle so a COMMIT has completed on return
  task automatic endPkt();
    packet_end = 1'b1; @(negedge clk); packet_end = 1'b0; @(negedge clk);
  endtask

  // n words: first CMD, rest DATA, data = seed+i; keep -> push to scoreboard
  task automatic sendPkt(input int n, input logic [15:0] seed, input bit keep,
                         input bit endWithLast);
    logic [17:0] w[$];
    logic [1:0]  t;
    logic [15:0] d;
    pulseStart();
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? 2'd0 : 2'd1;
      d = seed + 16'(i);
      in_request = 1'b1; in_type = t; in_data = d;
      if (endWithLast && i == n - 1) packet_end = 1'b1;
      w.push_back({t, d});
      @(negedge clk);
      in_request = 1'b0; packet_end = 1'b0;
    end
    if (!endWithLast) begin
      packet_end = 1'b1; @(negedge clk); packet_end = 1'b0;
    end
    @(negedge clk);
    if (keep) begin
      sbq.push_back({2'b11, 16'(n)});
      foreach (w[k]) sbq.push_back(w[k]);
    end
  endtask

  task automatic popOne(input string tag, input int hold);
    logic [17:0] exp;
    for (int i = 0; i < 12 && !pop_valid; i++) @(negedge clk);
    chk({tag, ".valid"}, 32'(pop_valid), 32'd1);
    exp = sbq.pop_front();
    chk(tag, {14'd0, pop_type, pop_data}, {14'd0, exp});
    if (hold > 0) begin
      cyc(hold);
      chk({tag, ".stable"}, {14'd0, pop_type, pop_data}, {14'd0, exp});
    end
    pop_ack = 1'b1; @(negedge clk); pop_ack = 1'b0;
  endtask

  task automatic popAll(input string tag);
    while (sbq.size() > 0) popOne(tag, 0);
    cyc(5);
    chk({tag, ".drained"}, 32'(pop_valid), 32'd0);
  endtask

  initial begin
    int d0;
    // ---------- reset state ----------
    cyc(2);
    chk("rst.pop_valid", 32'(pop_valid), 0);
    chk("rst.pending", 32'(packets_pending), 0);
    chk("rst.drop", 32'(drop_strobe), 0);
    rst = 1'b1;
    cyc(2);

    // ---------- basic packet ----------
    pulseStart();
    sendWord(2'd0, 16'h0821);
    sendWord(2'd1, 16'h1234);
    sendWord(2'd1, 16'h5678);
    endPkt();
    sbq.push_back({2'b11, 16'h0003});
    sbq.push_back({2'b00, 16'h0821});
    sbq.push_back({2'b01, 16'h1234});
    sbq.push_back({2'b01, 16'h5678});
    chk("basic.pending1", 32'(packets_pending), 1);
    popOne("basic.hdr", 3);
    chk("basic.pending0", 32'(packets_pending), 0);
    popAll("basic");

    // ---------- empty packet ----------
    d0 = dropCnt;
    sendPkt(0, 16'h0, 0, 0);
    cyc(5);
    chk("empty.valid", 32'(pop_valid), 0);
    chk("empty.drop", 32'(dropCnt - d0), 0);
    chk("empty.pending", 32'(packets_pending), 0);

    // ---------- error word ----------
    d0 = dropCnt;
    pulseStart();
    sendWord(2'd0, 16'h0821);
    sendWord(2'd2, 16'hDEAD);
    sendWord(2'd1, 16'h1111);
    endPkt();
`ifdef MIL_RX_ERR_KEEP_EN
    sbq.push_back({2'b11, 16'h8003});
    sbq.push_back({2'b00, 16'h0821});
    sbq.push_back({2'b10, 16'hDEAD});
    sbq.push_back({2'b01, 16'h1111});
    chk("err.drop", 32'(dropCnt - d0), 0);
    popAll("err");
`else
    cyc(5);
    chk("err.drop", 32'(dropCnt - d0), 1);
    chk("err.valid", 32'(pop_valid), 0);
    chk("err.pending", 32'(packets_pending), 0);
`endif

    // ---------- overlength ----------
    d0 = dropCnt;
    pulseStart();
    for (int i = 0; i < 33; i++) sendWord(2'd1, 16'hA000 + 16'(i));
    cyc(1);
    chk("ovl.noDropAt33", 32'(dropCnt - d0), 0);
    sendWord(2'd1, 16'hA0FF);
    cyc(1);
    chk("ovl.dropAt34", 32'(dropCnt - d0), 1);
    endPkt();
    cyc(4);
    chk("ovl.valid", 32'(pop_valid), 0);
    sendPkt(2, 16'hB000, 1, 1);   // last word together with the end strobe
    popAll("ovl.next");

    // ---------- full / wrap ----------
    d0 = dropCnt;
    sendPkt(31, 16'h1000, 1, 0);
    sendPkt(31, 16'h2000, 1, 0);
    chk("full.pending2", 32'(packets_pending), 2);
    sendPkt(3, 16'h3000, 0, 0);
    cyc(2);
    chk("full.drop", 32'(dropCnt - d0), 1);
    chk("full.pendingStill2", 32'(packets_pending), 2);
    popAll("full");
    chk("full.pending0", 32'(packets_pending), 0);
    for (int p = 0; p < 5; p++) begin
      sendPkt(20, 16'h4000 + 16'(p * 256), 1, 0);
      popAll("wrap");
    end
    chk("wrap.noDrop", 32'(dropCnt - d0), 1);

    // ---------- async reset mid-pop and mid-packet ----------
    sendPkt(1, 16'h5000, 1, 0);
    for (int i = 0; i < 12 && !pop_valid; i++) @(negedge clk);
    chk("rst2.preValid", 32'(pop_valid), 1);
    pulseStart();
    sendWord(2'd0, 16'h6000);
    #2 rst = 1'b0;
    #1;
    chk("rst2.valid", 32'(pop_valid), 0);
    chk("rst2.data", {14'd0, pop_type, pop_data}, 0);
    chk("rst2.pending", 32'(packets_pending), 0);
    chk("rst2.drop", 32'(drop_strobe), 0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    chk("rst2.idleValid", 32'(pop_valid), 0);
    sendPkt(1, 16'h7777, 1, 0);
    popAll("rst2.post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/mil_rx_packet_buffer.md
Name: mil_rx_packet_buffer

Overview:
- Receive-side stage directly downstream of the MIL-STD-1553 transceiver.
- Consumes received words plus packet start/end strobes, and assembles each bus packet into a circular word buffer with a header word.
- Commits only complete packets; drops overflowed or erroneous ones.
- Presents committed packets to the SPI-side reader through a valid/ack pop port.

Parameters:
- DEPTH, 64: buffer entries (18-bit type+data); power of two, at least 64.
- MAX_WORDS, 33: maximum words per packet (command + 32 data).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- in_request  in  1  one-cycle strobe: received word valid.
- in_data  in  16  received word payload.
- in_type  in  2  word type: 0 command/status sync, 1 data sync, 2 error.
- packet_start  in  1  one-cycle strobe: receiver became busy.
- packet_end  in  1  one-cycle strobe: receiver went idle.
- pop_valid  out  1  pop_data/pop_type hold a committed word.
- pop_data  out  16  buffered word.
- pop_type  out  2  word type; 3 = header.
- pop_ack  in  1  consume the current word; honoured only while pop_valid=1.
- packets_pending  out  6  committed, not yet popped packets, saturating at 63.
- drop_strobe  out  1  one-cycle pulse when a packet is discarded.

Behaviour:
- Reset (rst=0, async): all pointers, counters, pop_valid, pop_data, pop_type, packets_pending and drop_strobe clear to 0; FSM goes to IDLE. A partial packet is lost. Mid-packet reset is legal.
- Pointers are log2(DEPTH)+1 bits with wrap bit: wr_ptr (next write), commit_ptr, rd_ptr. Used = wr_ptr - rd_ptr modulo 2*DEPTH. Full when used == DEPTH.
- FSM states: IDLE, RECEIVE, COMMIT, DROP.
  - IDLE: on packet_start, go to RECEIVE. Header slot = commit_ptr; wr_ptr = commit_ptr+1; wcount = 0. in_request in IDLE is ignored.
  - RECEIVE, on in_request:
    - Error word (type 2): go to DROP.
    - Buffer full, or wcount == MAX_WORDS: go to DROP.
    - Otherwise: write {type,data} at wr_ptr, then wr_ptr+1 and wcount+1.
  - RECEIVE, on packet_end: go to COMMIT if wcount > 0; otherwise go to IDLE with nothing stored.
  - RECEIVE, in_request and packet_end in the same cycle: the word is processed first, then the end, so the word is included.
  - RECEIVE, packet_start: restart. The uncommitted packet is discarded silently; wr_ptr = commit_ptr+1.
  - COMMIT (1 cycle): write header {type 3, data[15]=err flag, data[5:0]=wcount, other bits 0} at the header slot. Then commit_ptr = wr_ptr, packets_pending+1, go to IDLE.
  - DROP: on entry, pulse drop_strobe for one cycle and set wr_ptr = commit_ptr. Ignore words until packet_end, then go to IDLE. packet_start while in DROP also goes to RECEIVE.
- Header-slot reservation: on packet_start the buffer needs at least 2 free entries. If fewer are free, go directly to DROP with the drop_strobe pulse.
- Read side:
  - Synchronous-read RAM feeds an output register.
  - When rd_ptr != commit_ptr and pop_valid=0, the word at rd_ptr is loaded and pop_valid rises 2 cycles later.
  - pop_ack with pop_valid=1: rd_ptr+1 and pop_valid clears next cycle. Throughput is 1 word per 3 cycles, sufficient for SPI.
  - pop_data and pop_type are stable while pop_valid=1 and pop_ack=0.
- packets_pending: +1 on commit; -1 when a header word is acked. Both in the same cycle leave it unchanged.
- Write and read never collide: the reader never passes commit_ptr, and the writer never passes rd_ptr.

Optional Feature:
- MIL_RX_ERR_KEEP_EN defined: an error word is stored like any other word and does not drop the packet. The committed header has data[15]=1 if any error word occurred in the packet.
- MIL_RX_ERR_KEEP_EN undefined: an error word sends the FSM to DROP, and header bit 15 is always 0.

Decomposition:
- Shared package mil_rx_pkg holds:
  - WordType enum (CMD=0, DATA=1, ERR=2, HDR=3);
  - the packed 18-bit buffer entry struct;
  - header field constants (HDR_ERR_BIT=15, HDR_CNT_W=6).
- Sub-module mil_rx_word_ram: simple dual-port RAM, DEPTH x 18, synchronous read, one write port, one read port.

Test Plan:
- Basic packet: start; CMD 0x0821; DATA 0x1234, 0x5678; end. Pops return HDR 0x0003, CMD 0x0821, DATA 0x1234, DATA 0x5678. packets_pending goes 1 then 0.
- Empty packet: start then end with no words. No commit, pop_valid stays 0, no drop_strobe.
- Error word: start; CMD; ERR; DATA; end. Without the macro: one drop_strobe pulse and nothing poppable. With it: HDR 0x8003 followed by 3 words.
- Overlength: 34 words in one packet produces drop_strobe on word 34. A following 2-word packet pops HDR 0x0002 intact.
- Full/wrap: fill with two 31-word packets (64 entries) without popping; a third packet is dropped. Pop everything, send 5 more packets across the pointer wrap; all data intact.
- Async reset asserted mid-packet and mid-pop: outputs go to 0 immediately. After release, a new 1-word packet pops HDR 0x0001 plus its word.
